// File: rtl/maxpool_core.sv
// maxpool_core: 2x2, stride-2 max pooling over a raster-order pixel stream.
// Each of the CO channels is pooled independently.
//
// Ports:
//   clk         rising-edge clock for all state
//   reset_n     synchronous active-low reset
//   i_in_valid  i_in_fmap carries one pixel (all channels) this cycle
//   i_in_fmap   CO unsigned samples; channel c at [c*I_F_BW +: I_F_BW]
//   o_ot_valid  single-cycle pulse, one per pooled pixel
//   o_ot_fmap   pooled pixel with the same channel packing; holds between pulses
//
// Data flow per accepted pixel:
//   even column            -> sample parked in pair_reg
//   odd column             -> hmax = max(pair_reg, sample)
//   even row, odd column   -> hmax stored in row_buf[col/2]
//   odd row,  even column  -> row_buf[col/2] fetched into rd_reg (registered read)
//   odd row,  odd column   -> max(rd_reg, hmax) registered to the output
// Fetching the row-buffer entry on the even column of the window keeps the
// buffer a plain synchronous-read memory while still giving one-clock latency.

module maxpool_core #(
  parameter int CO     = 3,
  parameter int I_F_BW = 19,
  parameter int OX     = 24,
  parameter int OY     = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_in_valid,
  input  logic [CO*I_F_BW-1:0] i_in_fmap,
  output logic                 o_ot_valid,
  output logic [CO*I_F_BW-1:0] o_ot_fmap
);

  localparam int DW   = CO * I_F_BW;
  localparam int HALF = OX / 2;
  localparam int CW   = $clog2(OX);
  localparam int RW   = $clog2(OY);
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  // Position counters
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;
  logic          col_last, row_last;

  // Datapath state
  logic [DW-1:0] pair_reg;
  logic [DW-1:0] rd_reg;
  logic [DW-1:0] row_buf [HALF];
  logic          ot_valid_reg;
  logic [DW-1:0] ot_fmap_reg;

  // Combinational helpers
  logic          accept;
  logic          odd_col, odd_row;
  logic          wr_en, rd_en, out_en;
  logic [AW-1:0] buf_idx;
  logic [DW-1:0] hmax;
  logic [DW-1:0] vmax;

  // Input is only honoured while out of reset.
  assign accept  = i_in_valid & reset_n;
  assign odd_col = col_reg[0];
  assign odd_row = row_reg[0];
  assign buf_idx = AW'(col_reg >> 1);

  assign wr_en   = accept &  odd_col & ~odd_row;
  assign rd_en   = accept & ~odd_col &  odd_row;
  assign out_en  = accept &  odd_col &  odd_row;

  // Counter next-state: column fastest, row advances on column wrap,
  // both wrap to zero at the last pixel of the frame.
  always_comb begin
    col_last = (col_reg == CW'(OX - 1));
    row_last = (row_reg == RW'(OY - 1));
    col_next = col_reg;
    row_next = row_reg;
    if (accept) begin
      if (col_last) begin
        col_next = '0;
        row_next = row_last ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  // Per-channel unsigned compares at full sample width.
  genvar gi;
  generate
    for (gi = 0; gi < CO; gi++) begin : g_ch
      logic [I_F_BW-1:0] pair_s;
      logic [I_F_BW-1:0] cur_s;
      logic [I_F_BW-1:0] rb_s;
      logic [I_F_BW-1:0] h_s;
      logic [I_F_BW-1:0] v_s;

      assign pair_s = pair_reg[gi*I_F_BW +: I_F_BW];
      assign cur_s  = i_in_fmap[gi*I_F_BW +: I_F_BW];
      assign rb_s   = rd_reg[gi*I_F_BW +: I_F_BW];
      // On a tie either operand is the common value.
      assign h_s    = (cur_s > pair_s) ? cur_s : pair_s;
      assign v_s    = (rb_s > h_s) ? rb_s : h_s;

      assign hmax[gi*I_F_BW +: I_F_BW] = h_s;
      assign vmax[gi*I_F_BW +: I_F_BW] = v_s;
    end
  endgenerate

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_reg      <= '0;
      row_reg      <= '0;
      pair_reg     <= '0;
      ot_valid_reg <= 1'b0;
      ot_fmap_reg  <= '0;
    end else begin
      col_reg      <= col_next;
      row_reg      <= row_next;
      ot_valid_reg <= out_en;
      if (accept && !odd_col) begin
        pair_reg <= i_in_fmap;
      end
      if (out_en) begin
        ot_fmap_reg <= vmax;
      end
    end
  end

  // Row buffer: written on even rows, read on the following odd row, so the
  // same entry is never written and read in one cycle. Contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      row_buf[buf_idx] <= hmax;
    end
    if (rd_en) begin
      rd_reg <= row_buf[buf_idx];
    end
  end

  assign o_ot_valid = ot_valid_reg;
  assign o_ot_fmap  = ot_fmap_reg;

endmodule

// File: tb/tb_maxpool_core.sv
// tb_maxpool_core: directed-vector bench with a scoreboard.
// Two instances: a 4x4 single-channel core for the small frame cases and a
// default-sized 24x24 three-channel core. Stimulus pushes expected pooled
// pixels (value and the cycle they must appear on) into per-instance queues;
// one monitor pops and compares whenever an instance raises o_ot_valid.

module tb_maxpool_core;

  localparam int W = 19;
  localparam logic [W-1:0] MAXV = 19'h7FFFF;

  typedef struct {
    logic [3*W-1:0] val;
    int             at;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           valid_s;
  logic [W-1:0]   fmap_s;
  logic           ov_s;
  logic [W-1:0]   of_s;
  logic           valid_l;
  logic [3*W-1:0] fmap_l;
  logic           ov_l;
  logic [3*W-1:0] of_l;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   seen_s = 0;
  int   seen_l = 0;
  exp_t q_s[$];
  exp_t q_l[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool_core #(.CO(1), .I_F_BW(W), .OX(4), .OY(4)) dut_s (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (valid_s),
    .i_in_fmap  (fmap_s),
    .o_ot_valid (ov_s),
    .o_ot_fmap  (of_s)
  );

  maxpool_core #(.CO(3), .I_F_BW(W), .OX(24), .OY(24)) dut_l (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (valid_l),
    .i_in_fmap  (fmap_l),
    .o_ot_valid (ov_l),
    .o_ot_fmap  (of_l)
  );

  // Monitor: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (ov_s === 1'b1) begin
      seen_s++;
      tests++;
      if (q_s.size() == 0) begin
        fails++;
        $display("FAIL small_unexpected: got %0d at cycle %0d, required no output", of_s, cyc);
      end else begin
        e = q_s.pop_front();
        if (of_s !== e.val[W-1:0] || cyc != e.at) begin
          fails++;
          $display("FAIL small_out: got %0d at cycle %0d, required %0d at cycle %0d",
                   of_s, cyc, e.val[W-1:0], e.at);
        end else begin
          $display("[TB] small out %0d at cycle %0d ok", of_s, cyc);
        end
      end
    end
    if (ov_l === 1'b1) begin
      seen_l++;
      tests++;
      if (q_l.size() == 0) begin
        fails++;
        $display("FAIL large_unexpected: got %h at cycle %0d, required no output", of_l, cyc);
      end else begin
        e = q_l.pop_front();
        if (of_l !== e.val || cyc != e.at) begin
          fails++;
          $display("FAIL large_out: got %h at cycle %0d, required %h at cycle %0d",
                   of_l, cyc, e.val, e.at);
        end else begin
          $display("[TB] large out %h at cycle %0d ok", of_l, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("[TB] %s = %0d ok", name, got);
    end
  endtask

  // Drive one small-core pixel for the next rising edge; optionally record
  // the output it must produce one cycle after that edge.
  task automatic px_s(input logic [W-1:0] v, input bit has_exp, input logic [W-1:0] ev);
    exp_t e;
    @(negedge clk);
    valid_s = 1'b1;
    fmap_s  = v;
    if (has_exp) begin
      e.val = {{(2*W){1'b0}}, ev};
      e.at  = cyc + 1;
      q_s.push_back(e);
    end
  endtask

  task automatic idle_s();
    @(negedge clk);
    valid_s = 1'b0;
    fmap_s  = 19'h2A5A5;
  endtask

  // One 4x4 frame; outputs come after raster pixels 5, 7, 13 and 15.
  task automatic run4(input logic [W-1:0] px[16], input logic [W-1:0] ex[4], input bit gaps);
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      bit has = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      px_s(px[i], has, has ? ex[k] : '0);
      if (has) k++;
      if (gaps) idle_s();
    end
  endtask

  initial begin
    logic [W-1:0] frame[16];
    logic [W-1:0] ex4[4];
    logic [W-1:0] ties[16];
    exp_t e;

    reset_n = 1'b0;
    valid_s = 1'b1;          // ignored while in reset
    fmap_s  = 19'h12345;
    valid_l = 1'b1;
    fmap_l  = '1;
    repeat (3) @(negedge clk);
    check("rst_valid_s", 64'(ov_s), 64'd0);
    check("rst_fmap_s", 64'(of_s), 64'd0);
    check("rst_valid_l", 64'(ov_l), 64'd0);
    check("rst_fmap_l", 64'(of_l), 64'd0);
    reset_n = 1'b1;
    valid_s = 1'b0;
    valid_l = 1'b0;
    fmap_l  = '0;
    @(negedge clk);

    // Raster-index frame, continuous valid.
    for (int i = 0; i < 16; i++) frame[i] = W'(i);
    ex4[0] = 19'd5; ex4[1] = 19'd7; ex4[2] = 19'd13; ex4[3] = 19'd15;
    run4(frame, ex4, 1'b0);
    idle_s();
    repeat (2) idle_s();

    // Same frame, valid toggling 1,0,1,0.
    run4(frame, ex4, 1'b1);
    repeat (2) idle_s();

    // Two back-to-back frames, second = first + 100.
    run4(frame, ex4, 1'b0);
    for (int i = 0; i < 16; i++) frame[i] = W'(i + 100);
    ex4[0] = 19'd105; ex4[1] = 19'd107; ex4[2] = 19'd113; ex4[3] = 19'd115;
    run4(frame, ex4, 1'b0);
    repeat (2) idle_s();

    // Reset after 6 pixels of a frame (pixel 5 still yields 5).
    for (int i = 0; i < 6; i++) px_s(W'(i), i == 5, 19'd5);
    @(negedge clk);
    reset_n = 1'b0;
    valid_s = 1'b1;
    fmap_s  = 19'h7ABCD;
    @(negedge clk);
    check("midrst_valid", 64'(ov_s), 64'd0);
    check("midrst_fmap", 64'(of_s), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    valid_s = 1'b0;
    @(negedge clk);
    check("postrst_valid", 64'(ov_s), 64'd0);
    check("postrst_fmap", 64'(of_s), 64'd0);
    for (int i = 0; i < 16; i++) frame[i] = W'(i);
    ex4[0] = 19'd5; ex4[1] = 19'd7; ex4[2] = 19'd13; ex4[3] = 19'd15;
    run4(frame, ex4, 1'b0);
    repeat (2) idle_s();

    // Ties: window of all max, window of all zero, then two mixed windows.
    ties = '{MAXV, MAXV, 19'd0, 19'd0,
             MAXV, MAXV, 19'd0, 19'd0,
             19'd1, 19'd2, 19'd3, 19'd4,
             19'd6, 19'd5, 19'd8, 19'd7};
    ex4[0] = MAXV; ex4[1] = 19'd0; ex4[2] = 19'd6; ex4[3] = 19'd8;
    run4(ties, ex4, 1'b0);
    repeat (2) idle_s();

    // 24x24, three channels.
    for (int r = 0; r < 24; r++) begin
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        valid_l = 1'b1;
        fmap_l  = {((r == 3 && c == 5) ? MAXV : 19'd0), W'(c), 19'd7};
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          e.val = {((r / 2 == 1 && c / 2 == 2) ? MAXV : 19'd0), W'(c), 19'd7};
          e.at  = cyc + 1;
          q_l.push_back(e);
        end
      end
    end
    @(negedge clk);
    valid_l = 1'b0;

    repeat (6) @(negedge clk);
    check("small_pending", 64'(q_s.size()), 64'd0);
    check("large_pending", 64'(q_l.size()), 64'd0);
    check("small_pulses", 64'(seen_s), 64'd25);
    check("large_pulses", 64'(seen_l), 64'd144);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
